// File: rtl/region_flasher.sv
// Raster-scans a clipped window of frame memory and emits one plot per pixel; RD_LAT+2 cycles per pixel,
// plot_* held stable while plot_en waits on plot_ready; start/done continuation handshake with done_ack.
`timescale 1ns/1ps
module region_flasher #(
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_BITS = 3,
  parameter int RD_LAT     = 1
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [X_BITS-1:0]     win_x0,
  input  logic [Y_BITS-1:0]     win_y0,
  input  logic [X_BITS:0]       win_w,
  input  logic [Y_BITS:0]       win_h,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [COLOR_BITS-1:0] rd_data,
  output logic [X_BITS-1:0]     plot_x,
  output logic [Y_BITS-1:0]     plot_y,
  output logic [COLOR_BITS-1:0] plot_colour,
  output logic                  plot_en,
  input  logic                  plot_ready,
  output logic                  busy,
  output logic                  done,
  input  logic                  done_ack
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [X_BITS+1:0] SCR_W_S = (X_BITS+2)'(SCR_W);
  localparam logic [Y_BITS+1:0] SCR_H_S = (Y_BITS+2)'(SCR_H);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PLOT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic [X_BITS-1:0]     x_q, x_d, x0_q, x0_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  logic [X_BITS:0]       x_end_q, x_end_d;
  logic [Y_BITS:0]       y_end_q, y_end_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic [X_BITS-1:0]     plot_x_q, plot_x_d;
  logic [Y_BITS-1:0]     plot_y_q, plot_y_d;
  logic [COLOR_BITS-1:0] plot_col_q, plot_col_d;
  logic                  plot_en_q, plot_en_d;

  logic [X_BITS+1:0] x_sum;
  logic [Y_BITS+1:0] y_sum;
  logic [X_BITS:0]   x_clip, x_inc;
  logic [Y_BITS:0]   y_clip, y_inc;
  logic              win_empty;

  function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [X_BITS-1:0] px,
                                                    input logic [Y_BITS-1:0] py);
    return ADDR_BITS'(py) * ADDR_BITS'(SCR_W) + ADDR_BITS'(px);
  endfunction

  // Sums carry an extra bit so an oversized window clips instead of wrapping.
  assign x_sum     = {2'b00, win_x0} + {1'b0, win_w};
  assign y_sum     = {2'b00, win_y0} + {1'b0, win_h};
  assign x_clip    = (x_sum > SCR_W_S) ? SCR_W_S[X_BITS:0] : x_sum[X_BITS:0];
  assign y_clip    = (y_sum > SCR_H_S) ? SCR_H_S[Y_BITS:0] : y_sum[Y_BITS:0];
  assign win_empty = (win_w == '0) || (win_h == '0) ||
                     ({2'b00, win_x0} >= SCR_W_S) || ({2'b00, win_y0} >= SCR_H_S);
  assign x_inc     = (X_BITS+1)'(x_q) + (X_BITS+1)'(1);
  assign y_inc     = (Y_BITS+1)'(y_q) + (Y_BITS+1)'(1);

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      x0_q       <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      plot_x_q   <= '0;
      plot_y_q   <= '0;
      plot_col_q <= '0;
      plot_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x0_q       <= x0_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      plot_x_q   <= plot_x_d;
      plot_y_q   <= plot_y_d;
      plot_col_q <= plot_col_d;
      plot_en_q  <= plot_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    x_d        = x_q;
    y_d        = y_q;
    x0_d       = x0_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    plot_x_d   = plot_x_q;
    plot_y_d   = plot_y_q;
    plot_col_d = plot_col_q;
    plot_en_d  = plot_en_q;
    case (state_q)
      S_IDLE: begin
        // busy while still in IDLE marks an accepted empty window: one busy cycle, then DONE.
        if (busy_q) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (start) begin
          busy_d  = 1'b1;
          x0_d    = win_x0;
          x_end_d = x_clip;
          y_end_d = y_clip;
          if (!win_empty) begin
            x_d       = win_x0;
            y_d       = win_y0;
            rd_addr_d = pix_addr(win_x0, win_y0);
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          plot_col_d = rd_data;
          plot_x_d   = x_q;
          plot_y_d   = y_q;
          plot_en_d  = 1'b1;
          state_d    = S_PLOT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PLOT: begin
        if (plot_ready) begin
          plot_en_d = 1'b0;
          if (x_inc < x_end_q) begin
            x_d       = x_inc[X_BITS-1:0];
            rd_addr_d = pix_addr(x_inc[X_BITS-1:0], y_q);
            state_d   = S_ISSUE;
          end else if (y_inc < y_end_q) begin
            x_d       = x0_q;
            y_d       = y_inc[Y_BITS-1:0];
            rd_addr_d = pix_addr(x0_q, y_inc[Y_BITS-1:0]);
            state_d   = S_ISSUE;
          end else begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (done_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr     = rd_addr_q;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = plot_col_q;
  assign plot_en     = plot_en_q;
  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_region_flasher.sv
// Directed bench for region_flasher: one instance at RD_LAT=1 and one at RD_LAT=3, each with a
// pipelined memory returning addr[2:0]; shared stimulus, outputs selected by sel.
`timescale 1ns/1ps
module tb_region_flasher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] win_x0 = '0;
  logic [6:0] win_y0 = '0;
  logic [8:0] win_w = '0;
  logic [7:0] win_h = '0;
  logic       plot_ready = 1'b0;
  logic       done_ack = 1'b0;
  logic       sel = 1'b0;

  logic [14:0] a_rd_addr, b_rd_addr;
  logic [2:0]  a_rd_data, b_rd_data;
  logic [7:0]  a_plot_x, b_plot_x;
  logic [6:0]  a_plot_y, b_plot_y;
  logic [2:0]  a_plot_col, b_plot_col;
  logic        a_plot_en, b_plot_en, a_busy, b_busy, a_done, b_done;

  logic [2:0] a_p1;
  logic [8:0] b_p;

  int n_checks = 0;
  int n_errors = 0;
  int last_x, last_y;

  always #5 clk = ~clk;

  region_flasher #(.RD_LAT(1)) dut_a (
    .Clck(clk), .Reset(rst_n), .start(start),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .plot_x(a_plot_x), .plot_y(a_plot_y), .plot_colour(a_plot_col), .plot_en(a_plot_en),
    .plot_ready(plot_ready), .busy(a_busy), .done(a_done), .done_ack(done_ack)
  );

  region_flasher #(.RD_LAT(3)) dut_b (
    .Clck(clk), .Reset(rst_n), .start(start),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .plot_x(b_plot_x), .plot_y(b_plot_y), .plot_colour(b_plot_col), .plot_en(b_plot_en),
    .plot_ready(plot_ready), .busy(b_busy), .done(b_done), .done_ack(done_ack)
  );

  // Memory content is addr[2:0]; pipeline depth equals each instance's read latency.
  always @(posedge clk) begin
    a_p1 <= a_rd_addr[2:0];
    b_p  <= {b_p[5:0], b_rd_addr[2:0]};
  end
  assign a_rd_data = a_p1;
  assign b_rd_data = b_p[8:6];

  logic [14:0] m_rd_addr;
  logic [7:0]  m_plot_x;
  logic [6:0]  m_plot_y;
  logic [2:0]  m_plot_col;
  logic        m_plot_en, m_busy, m_done;
  assign m_rd_addr  = sel ? b_rd_addr  : a_rd_addr;
  assign m_plot_x   = sel ? b_plot_x   : a_plot_x;
  assign m_plot_y   = sel ? b_plot_y   : a_plot_y;
  assign m_plot_col = sel ? b_plot_col : a_plot_col;
  assign m_plot_en  = sel ? b_plot_en  : a_plot_en;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_addr"}, 32'(m_rd_addr), 0);
    check({tag, "_plot_x"},  32'(m_plot_x), 0);
    check({tag, "_plot_y"},  32'(m_plot_y), 0);
    check({tag, "_colour"},  32'(m_plot_col), 0);
    check({tag, "_plot_en"}, 32'(m_plot_en), 0);
    check({tag, "_busy"},    32'(m_busy), 0);
    check({tag, "_done"},    32'(m_done), 0);
  endtask

  task automatic finish_done();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    tick();
  endtask

  // Starts a scan and follows it to done. xe/ye are the hand-clipped window ends, bp the number
  // of cycles plot_ready stays low at the start of each plot, exp_done the edges from start
  // acceptance to done. stop_after>0 leaves the scan running right after that many plots.
  task automatic run_scan(input string tag, input int x0, input int y0, input int w, input int h,
                          input int xe, input int ye, input int bp, input int exp_n,
                          input int exp_done, input int stop_after);
    int k, cyc, hold, bad_stab, en_cyc, ex, ey, ea;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    k = 0; cyc = 0; hold = 0; bad_stab = 0; en_cyc = 0; ex = x0; ey = y0;
    hx = '0; hy = '0; hc = '0;
    win_x0 = 8'(x0); win_y0 = 7'(y0); win_w = 9'(w); win_h = 8'(h);
    plot_ready = (bp == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_at_accept"}, 32'(m_busy), 1);
    while (cyc < 60000) begin
      // A start with a different window mid-scan must change nothing.
      if (cyc == 5) begin
        start = 1'b1; win_x0 = 8'd1; win_y0 = 7'd1; win_w = 9'd7; win_h = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (m_done) break;
      if (m_plot_en) begin
        en_cyc++;
        if (hold == 0) begin
          hx = m_plot_x; hy = m_plot_y; hc = m_plot_col;
        end else if (m_plot_x != hx || m_plot_y != hy || m_plot_col != hc) begin
          bad_stab++;
        end
        hold++;
        plot_ready = (hold > bp);
        if (plot_ready) begin
          ea = ey * 160 + ex;
          check({tag, "_x"},      32'(m_plot_x), 32'(ex));
          check({tag, "_y"},      32'(m_plot_y), 32'(ey));
          check({tag, "_addr"},   32'(m_rd_addr), 32'(ea));
          check({tag, "_colour"}, 32'(m_plot_col), 32'(ea % 8));
          last_x = m_plot_x; last_y = m_plot_y;
          hold = 0;
          k++;
          ex++;
          if (ex >= xe) begin
            ex = x0;
            ey++;
          end
          if (k == stop_after) begin
            start = 1'b0;
            return;
          end
        end
      end else begin
        plot_ready = (bp == 0);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_no_timeout"}, 32'(cyc < 60000), 1);
    check({tag, "_plots"}, 32'(k), 32'(exp_n));
    check({tag, "_en_cycles"}, 32'(en_cyc), 32'(exp_n * (bp + 1)));
    check({tag, "_done_latency"}, 32'(cyc), 32'(exp_done));
    check({tag, "_stable"}, 32'(bad_stab), 0);
    check({tag, "_busy_in_done"}, 32'(m_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int held;
    rst_n = 1'b0;
    tick();
    tick();
    check_zero("reset_a");
    rst_n = 1'b1;
    tick();

    run_scan("full", 0, 0, 160, 120, 160, 120, 0, 19200, 57600, 0);
    check("full_last_x", 32'(last_x), 159);
    check("full_last_y", 32'(last_y), 119);

    // done stays up without ack; start during DONE and with the ack is ignored.
    held = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_done && !m_busy && !m_plot_en) held++;
      tick();
    end
    check("done_held", 32'(held), 10);
    done_ack = 1'b1;
    tick();
    check("ack_clears_done", 32'(m_done), 0);
    check("ack_start_ignored", 32'(m_busy), 0);
    start = 1'b0;
    done_ack = 1'b0;
    tick();
    tick();
    check("idle_after_ack_busy", 32'(m_busy), 0);
    check("idle_after_ack_en", 32'(m_plot_en), 0);

    run_scan("win", 10, 5, 3, 2, 13, 7, 0, 6, 18, 0);
    check("win_last_x", 32'(last_x), 12);
    check("win_last_y", 32'(last_y), 6);
    finish_done();
    run_scan("clip", 158, 119, 5, 5, 160, 120, 0, 2, 6, 0);
    finish_done();
    run_scan("empty_w", 20, 20, 0, 4, 20, 24, 0, 0, 1, 0);
    finish_done();
    run_scan("empty_x", 170, 0, 4, 4, 160, 4, 0, 0, 1, 0);
    finish_done();

    run_scan("rst_scan", 0, 0, 160, 120, 160, 120, 0, 0, 0, 50);
    check("rst_scan_plots", 32'(last_x), 49);
    rst_n = 1'b0;
    tick();
    check_zero("mid_reset");
    rst_n = 1'b1;
    tick();
    run_scan("post_rst", 20, 30, 2, 2, 22, 32, 0, 4, 12, 0);
    finish_done();

    sel = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check_zero("reset_b");
    rst_n = 1'b1;
    tick();
    run_scan("bp_win", 10, 5, 3, 2, 13, 7, 4, 6, 54, 0);
    finish_done();
    run_scan("bp_clip", 158, 118, 4, 2, 160, 120, 4, 4, 36, 0);
    finish_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
